// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word hold register so that words
// arriving back to back stream out with no idle cycles between them.
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x,
   output logic             x_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [WIDTH-1:0] hold, hold_nxt;
   logic             hold_full, hold_full_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] shreg_shifted;
   logic             accept;

   assign in_ready = !hold_full && rst_n;
   assign accept   = in_valid && in_ready;

   // Shift toward whichever end feeds x.
   assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg[WIDTH-1:1]};

   assign x_valid   = (state == SHIFT);
   assign x         = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 1'b0;
   assign word_done = (state == SHIFT) && (cnt == LAST);
   assign busy      = (state == SHIFT) || hold_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         cnt       <= '0;
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         hold      <= hold_nxt;
         hold_full <= hold_full_nxt;
         cnt       <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      shreg_nxt     = shreg;
      hold_nxt      = hold;
      hold_full_nxt = hold_full;
      cnt_nxt       = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               shreg_nxt = in_data;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt != LAST) begin
               shreg_nxt = shreg_shifted;
               cnt_nxt   = cnt + CNT_W'(1);
               if (accept) begin
                  hold_nxt      = in_data;
                  hold_full_nxt = 1'b1;
               end
            end else if (hold_full) begin
               // in_ready is low here, so no new word competes with the hold load.
               shreg_nxt     = hold;
               hold_full_nxt = 1'b0;
               cnt_nxt       = '0;
            end else if (accept) begin
               shreg_nxt = in_data;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first instance for most scenarios
// and an LSB-first instance for the bit-order scenario.
module tb_bit_serializer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready, x, x_valid, word_done, busy;
   logic [7:0] in_data_l;
   logic       in_valid_l;
   logic       in_ready_l, x_l, x_valid_l, word_done_l, busy_l;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .x(x), .x_valid(x_valid), .word_done(word_done), .busy(busy)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .in_data(in_data_l), .in_valid(in_valid_l),
      .in_ready(in_ready_l), .x(x_l), .x_valid(x_valid_l), .word_done(word_done_l), .busy(busy_l)
   );

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_valid_l = 1'b0; in_data_l = '0;
      #12;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL reset_x_valid: got %b expected 0", x_valid); end
      vectors++; if (x !== 1'b0) begin miscompares++; $display("FAIL reset_x: got %b expected 0", x); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (word_done !== 1'b0) begin miscompares++; $display("FAIL reset_word_done: got %b expected 0", word_done); end
      @(negedge clk); rst_n = 1'b1; #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_idle();
      for (int c = 0; c < 20; c++) begin
         vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL idle_x_valid c=%0d: got %b expected 0", c, x_valid); end
         vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy c=%0d: got %b expected 0", c, busy); end
         vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_in_ready c=%0d: got %b expected 1", c, in_ready); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_single();
      logic [7:0] exp;
      exp = 8'hB0;
      in_valid = 1'b1; in_data = 8'hB0;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         vectors++; if (x_valid !== 1'b1) begin miscompares++; $display("FAIL single_x_valid bit%0d: got %b expected 1", i, x_valid); end
         vectors++; if (x !== exp[7-i]) begin miscompares++; $display("FAIL single_x bit%0d: got %b expected %b", i, x, exp[7-i]); end
         vectors++; if (word_done !== (i == 7)) begin miscompares++; $display("FAIL single_word_done bit%0d: got %b expected %b", i, word_done, (i == 7)); end
         @(posedge clk); #1;
      end
      vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL single_after_x_valid: got %b expected 0", x_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_after_busy: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  words [3];
      logic [23:0] exp, got;
      logic [23:0] det_exp, det_got;
      logic        acc;
      int          idx;
      words[0] = 8'hB0; words[1] = 8'hB6; words[2] = 8'h0B;
      exp = 24'hB0B60B;
      det_exp = '0;
      det_exp[23-0] = 1'b1; det_exp[23-8] = 1'b1; det_exp[23-11] = 1'b1; det_exp[23-20] = 1'b1;
      got = '0;
      idx = 0;
      in_valid = 1'b1; in_data = words[0];
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1; if (acc) idx++;
      for (int k = 0; k < 24; k++) begin
         if (idx < 3) begin in_valid = 1'b1; in_data = words[idx]; end
         else in_valid = 1'b0;
         got[23-k] = x;
         vectors++; if (x_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_x_valid k=%0d: got %b expected 1", k, x_valid); end
         vectors++; if (x !== exp[23-k]) begin miscompares++; $display("FAIL b2b_x k=%0d: got %b expected %b", k, x, exp[23-k]); end
         vectors++; if (word_done !== ((k % 8) == 7)) begin miscompares++; $display("FAIL b2b_word_done k=%0d: got %b expected %b", k, word_done, ((k % 8) == 7)); end
         @(negedge clk); acc = in_valid && in_ready;
         @(posedge clk); #1; if (acc) idx++;
      end
      in_valid = 1'b0;
      det_got = '0;
      for (int p = 0; p <= 20; p++)
         if (got[23-p] && !got[22-p] && got[21-p] && got[20-p]) det_got[23-p] = 1'b1;
      vectors++; if (det_got !== det_exp) begin miscompares++; $display("FAIL b2b_detect: got %h expected %h", det_got, det_exp); end
      vectors++; if (idx != 3) begin miscompares++; $display("FAIL b2b_accepts: got %0d expected 3", idx); end
      vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_after_x_valid: got %b expected 0", x_valid); end
   endtask

   task automatic test_hold();
      logic [23:0] exp;
      exp = 24'hA53CC3;
      in_valid = 1'b1; in_data = 8'hA5;
      @(posedge clk); #1;
      for (int k = 0; k < 24; k++) begin
         vectors++; if (x !== exp[23-k]) begin miscompares++; $display("FAIL hold_x k=%0d: got %b expected %b", k, x, exp[23-k]); end
         vectors++; if (x_valid !== 1'b1) begin miscompares++; $display("FAIL hold_x_valid k=%0d: got %b expected 1", k, x_valid); end
         if (k <= 8) begin
            vectors++;
            if (in_ready !== (k == 0 || k == 8)) begin
               miscompares++; $display("FAIL hold_in_ready k=%0d: got %b expected %b", k, in_ready, (k == 0 || k == 8));
            end
         end
         if (k == 1) begin
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL hold_busy: got %b expected 1", busy); end
         end
         if (k == 0) in_data = 8'h3C;
         else if (k <= 8) in_data = 8'hC3;
         else in_valid = 1'b0;
         @(posedge clk); #1;
      end
      vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL hold_after_x_valid: got %b expected 0", x_valid); end
   endtask

   task automatic test_lsb();
      logic [7:0] exp;
      exp = 8'b10110000;
      in_valid_l = 1'b1; in_data_l = 8'h0D;
      @(posedge clk); #1;
      in_valid_l = 1'b0;
      for (int i = 0; i < 8; i++) begin
         vectors++; if (x_valid_l !== 1'b1) begin miscompares++; $display("FAIL lsb_x_valid bit%0d: got %b expected 1", i, x_valid_l); end
         vectors++; if (x_l !== exp[7-i]) begin miscompares++; $display("FAIL lsb_x bit%0d: got %b expected %b", i, x_l, exp[7-i]); end
         @(posedge clk); #1;
      end
      vectors++; if (x_valid_l !== 1'b0) begin miscompares++; $display("FAIL lsb_after_x_valid: got %b expected 0", x_valid_l); end
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; in_data = 8'hFF;
      @(posedge clk); #1;
      in_data = 8'h55;
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_held_in_ready: got %b expected 0", in_ready); end
      repeat (3) begin @(posedge clk); #1; end
      vectors++; if (x !== 1'b1 || x_valid !== 1'b1) begin miscompares++; $display("FAIL mid_bit4: got x=%b v=%b expected x=1 v=1", x, x_valid); end
      rst_n = 1'b0; #1;
      vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_x_valid: got %b expected 0", x_valid); end
      vectors++; if (x !== 1'b0) begin miscompares++; $display("FAIL mid_rst_x: got %b expected 0", x); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_in_ready: got %b expected 0", in_ready); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 12; c++) begin
         vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL mid_residual_x_valid c=%0d: got %b expected 0", c, x_valid); end
         vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_after_in_ready c=%0d: got %b expected 1", c, in_ready); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_hold();
      test_lsb();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
